resp_demux: RTL and testbench

Routes a single shared response stream from a bus slave back to exactly one of NUM_OF_OUTPUT masters, selected by the same SEL code the master-side multiplexer uses for requests. The block latches SEL at transaction start and holds the route until the transaction ends or times out. It sits on the return path of the DSP controller's master/slave interconnect.

---
 rtl/resp_demux_pkg.sv | 27 ++
 rtl/resp_demux_if.sv | 32 +++
 rtl/resp_demux_sel_decoder.sv | 20 ++
 rtl/resp_demux.sv | 106 ++++++++++
 tb/tb_resp_demux.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/resp_demux_pkg.sv
// Shared definitions for the response demultiplexer and its request-side siblings.
// Holds state encodings, default widths and the idle-counter width helper.
package resp_demux_pkg;

    localparam int unsigned DEFAULT_NUM_OF_OUTPUT   = 4;
    localparam int unsigned DEFAULT_NUM_OF_SEL_BITS = 2;
    localparam int unsigned DEFAULT_DATA_WIDTH      = 16;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES  = 255;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACTIVE = 1'b1;

    typedef enum logic {
        StIdle   = ST_IDLE,
        StActive = ST_ACTIVE
    } state_e;

    // Counter must hold values up to TIMEOUT_CYCLES-1; capped at 16 bits.
    function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
        int unsigned w;
        w = $clog2(timeout_cycles + 1);
        if (w > 16) w = 16;
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/resp_demux_if.sv
// Response-path bundle between the shared slave response stream and the demux.
// The slave modport is the demux side; master is the driver/observer side.
interface resp_demux_if
    import resp_demux_pkg::*;
#(
    parameter int unsigned NUM_OF_OUTPUT   = DEFAULT_NUM_OF_OUTPUT,
    parameter int unsigned NUM_OF_SEL_BITS = DEFAULT_NUM_OF_SEL_BITS,
    parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH
);

    logic [NUM_OF_SEL_BITS-1:0] sel;
    logic                       start;
    logic                       in_valid;
    logic [DATA_WIDTH-1:0]      in_data;
    logic                       in_last;
    logic [NUM_OF_OUTPUT-1:0]   out_valid;
    logic [DATA_WIDTH-1:0]      out_data;
    logic                       out_last;
    logic                       busy;
    logic                       timeout;

    modport master (
        output sel, start, in_valid, in_data, in_last,
        input  out_valid, out_data, out_last, busy, timeout
    );

    modport slave (
        input  sel, start, in_valid, in_data, in_last,
        output out_valid, out_data, out_last, busy, timeout
    );

endinterface

// File: rtl/resp_demux_sel_decoder.sv
// Binary-to-one-hot decoder with range check; codes >= NUM_OF_OUTPUT decode to
// all zeros and deassert valid_o.
module sel_decoder #(
    parameter int unsigned NUM_OF_OUTPUT   = 4,
    parameter int unsigned NUM_OF_SEL_BITS = 2
) (
    input  logic [NUM_OF_SEL_BITS-1:0] sel_i,
    output logic [NUM_OF_OUTPUT-1:0]   onehot_o,
    output logic                       valid_o
);

    always_comb begin
        valid_o  = (32'(sel_i) < NUM_OF_OUTPUT);
        onehot_o = '0;
        for (int unsigned i = 0; i < NUM_OF_OUTPUT; i++) begin
            onehot_o[i] = (32'(sel_i) == i);
        end
    end

endmodule

// File: rtl/resp_demux.sv
// Routes the shared response stream to the master latched at transaction start,
// with an idle timer that aborts stalled transactions.
module resp_demux
    import resp_demux_pkg::*;
#(
    parameter int unsigned NUM_OF_OUTPUT   = DEFAULT_NUM_OF_OUTPUT,
    parameter int unsigned NUM_OF_SEL_BITS = DEFAULT_NUM_OF_SEL_BITS,
    parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic         clk_i,
    input  logic         rst_i,
    resp_demux_if.slave  bus
);

    localparam int unsigned CntWidth = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CntWidth-1:0] CntLimit = CntWidth'(TIMEOUT_CYCLES - 1);

    state_e                     state_q, state_d;
    logic [NUM_OF_SEL_BITS-1:0] sel_q, sel_d;
    logic [CntWidth-1:0]        cnt_q, cnt_d;
    logic [NUM_OF_OUTPUT-1:0]   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;
    logic                       out_last_q, out_last_d;
    logic                       timeout_q, timeout_d;

    logic [NUM_OF_OUTPUT-1:0]   sel_onehot;
    logic                       sel_valid;

    sel_decoder #(
        .NUM_OF_OUTPUT   (NUM_OF_OUTPUT),
        .NUM_OF_SEL_BITS (NUM_OF_SEL_BITS)
    ) u_sel_decoder (
        .sel_i    (sel_q),
        .onehot_o (sel_onehot),
        .valid_o  (sel_valid)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        out_valid_d = '0;
        out_data_d  = out_data_q;
        out_last_d  = 1'b0;
        timeout_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sel_d   = bus.sel;
                    cnt_d   = '0;
                    state_d = StActive;
                end
            end
            StActive: begin
                if (bus.in_valid) begin
                    cnt_d = '0;
                    // Out-of-range routes still track LAST but emit nothing.
                    if (sel_valid) begin
                        out_valid_d = sel_onehot;
                        out_data_d  = bus.in_data;
                        out_last_d  = bus.in_last;
                    end
                    if (bus.in_last) begin
                        state_d = StIdle;
                    end
                end else if (cnt_q == CntLimit) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q == StActive);
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_resp_demux.sv
// Scoreboard bench for resp_demux: a default 4-master instance and a 3-master
// instance with a 4-cycle timeout.
module tb_resp_demux;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    resp_demux_if #(.NUM_OF_OUTPUT(4), .NUM_OF_SEL_BITS(2), .DATA_WIDTH(16)) a_if ();
    resp_demux_if #(.NUM_OF_OUTPUT(3), .NUM_OF_SEL_BITS(2), .DATA_WIDTH(16)) b_if ();

    resp_demux #(
        .NUM_OF_OUTPUT   (4),
        .NUM_OF_SEL_BITS (2),
        .DATA_WIDTH      (16),
        .TIMEOUT_CYCLES  (255)
    ) u_dut_a (
        .clk_i (clk),
        .rst_i (rst_a),
        .bus   (a_if)
    );

    resp_demux #(
        .NUM_OF_OUTPUT   (3),
        .NUM_OF_SEL_BITS (2),
        .DATA_WIDTH      (16),
        .TIMEOUT_CYCLES  (4)
    ) u_dut_b (
        .clk_i (clk),
        .rst_i (rst_b),
        .bus   (b_if)
    );

    typedef struct packed {
        logic [3:0]  v;
        logic [15:0] d;
        logic        l;
        logic        b;
        logic        t;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   checks = 0;
    int   passed = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic st, input logic [1:0] sel, input logic v,
                         input logic [15:0] d, input logic l);
        a_if.start    = st;
        a_if.sel      = sel;
        a_if.in_valid = v;
        a_if.in_data  = d;
        a_if.in_last  = l;
    endtask

    task automatic drv_b(input logic st, input logic [1:0] sel, input logic v,
                         input logic [15:0] d, input logic l);
        b_if.start    = st;
        b_if.sel      = sel;
        b_if.in_valid = v;
        b_if.in_data  = d;
        b_if.in_last  = l;
    endtask

    // Drive one routed beat on instance A and record its expected response.
    task automatic beat_a(input logic [15:0] d, input logic l, input logic [3:0] ev);
        drv_a(1'b0, 2'd0, 1'b1, d, l);
        qa.push_back('{v: ev, d: d, l: l, b: ~l, t: 1'b0});
        tick();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (a_if.out_valid !== 4'b0 || a_if.timeout !== 1'b0) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_out", {a_if.out_valid, a_if.timeout}, 32'd0);
                end else begin
                    ea = qa.pop_front();
                    chk("a_out_valid", a_if.out_valid, ea.v);
                    chk("a_out_data", a_if.out_data, ea.d);
                    chk("a_out_last", a_if.out_last, ea.l);
                    chk("a_busy", a_if.busy, ea.b);
                    chk("a_timeout", a_if.timeout, ea.t);
                end
            end
            if (b_if.out_valid !== 3'b0 || b_if.timeout !== 1'b0) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_out", {b_if.out_valid, b_if.timeout}, 32'd0);
                end else begin
                    eb = qb.pop_front();
                    chk("b_out_valid", {1'b0, b_if.out_valid}, eb.v);
                    chk("b_out_data", b_if.out_data, eb.d);
                    chk("b_out_last", b_if.out_last, eb.l);
                    chk("b_busy", b_if.busy, eb.b);
                    chk("b_timeout", b_if.timeout, eb.t);
                end
            end
        end
    end

    initial begin
        drv_a(1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
        drv_b(1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        chk("rst_a_out_valid", a_if.out_valid, 32'd0);
        chk("rst_a_out_data", a_if.out_data, 32'd0);
        chk("rst_a_out_last", a_if.out_last, 32'd0);
        chk("rst_a_busy", a_if.busy, 32'd0);
        chk("rst_a_timeout", a_if.timeout, 32'd0);
        chk("rst_b_out_valid", b_if.out_valid, 32'd0);
        chk("rst_b_busy", b_if.busy, 32'd0);
        mon_en = 1'b1;
        tick();

        // Three beats to master 2, LAST on the third.
        drv_a(1'b1, 2'd2, 1'b0, 16'h0, 1'b0);
        tick();
        chk("t1_busy_rise", a_if.busy, 32'd1);
        beat_a(16'h0011, 1'b0, 4'b0100);
        beat_a(16'h0022, 1'b0, 4'b0100);
        beat_a(16'h0033, 1'b1, 4'b0100);
        chk("t1_busy_fall", a_if.busy, 32'd0);
        drv_a(1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
        tick();

        // START with SEL=3 while busy must not move the route off master 1.
        drv_a(1'b1, 2'd1, 1'b0, 16'h0, 1'b0);
        tick();
        beat_a(16'h00a1, 1'b0, 4'b0010);
        drv_a(1'b1, 2'd3, 1'b1, 16'h00a2, 1'b0);
        qa.push_back('{v: 4'b0010, d: 16'h00a2, l: 1'b0, b: 1'b1, t: 1'b0});
        tick();
        beat_a(16'h00a3, 1'b1, 4'b0010);
        drv_a(1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
        tick();

        // Beat coincident with START is dropped; the next one is routed.
        drv_a(1'b1, 2'd0, 1'b1, 16'hdead, 1'b0);
        tick();
        beat_a(16'h0055, 1'b1, 4'b0001);
        drv_a(1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
        tick();

        // Reset on the second of four beats.
        drv_a(1'b1, 2'd3, 1'b0, 16'h0, 1'b0);
        tick();
        beat_a(16'h1111, 1'b0, 4'b1000);
        drv_a(1'b0, 2'd0, 1'b1, 16'h2222, 1'b0);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        drv_a(1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
        chk("t6_out_valid", a_if.out_valid, 32'd0);
        chk("t6_out_data", a_if.out_data, 32'd0);
        chk("t6_out_last", a_if.out_last, 32'd0);
        chk("t6_busy", a_if.busy, 32'd0);
        tick();
        drv_a(1'b1, 2'd0, 1'b0, 16'h0, 1'b0);
        tick();
        beat_a(16'h0777, 1'b1, 4'b0001);
        drv_a(1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
        tick();

        // Timeout on instance B: four idle ACTIVE cycles.
        drv_b(1'b1, 2'd0, 1'b0, 16'h0, 1'b0);
        tick();
        drv_b(1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
        chk("t4_busy_rise", b_if.busy, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) qb.push_back('{v: 4'b0, d: 16'h0, l: 1'b0, b: 1'b0, t: 1'b1});
            tick();
            chk($sformatf("t4_timeout_c%0d", i), b_if.timeout, (i == 4) ? 32'd1 : 32'd0);
            chk($sformatf("t4_busy_c%0d", i), b_if.busy, (i == 4) ? 32'd0 : 32'd1);
        end
        tick();
        chk("t4_timeout_pulse_end", b_if.timeout, 32'd0);

        // Out-of-range SEL on the 3-master instance: no strobes, BUSY still clears.
        drv_b(1'b1, 2'd3, 1'b0, 16'h0, 1'b0);
        tick();
        drv_b(1'b0, 2'd0, 1'b1, 16'h00b1, 1'b0);
        tick();
        chk("t3_busy_mid", b_if.busy, 32'd1);
        drv_b(1'b0, 2'd0, 1'b1, 16'h00b2, 1'b1);
        tick();
        chk("t3_busy_fall", b_if.busy, 32'd0);
        drv_b(1'b0, 2'd0, 1'b0, 16'h0, 1'b0);

        tick();
        tick();
        tick();
        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
